// File: rtl/pcie_adapter_pkg.sv
// Shared definitions for the PCIe user-TX adapter: header field map, beat size
// and the request-splitter FSM encoding.
package pcie_adapter_pkg;
  localparam int HDR_W        = 144;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_LEN_LSB  = 64;
  localparam int HDR_RD_BIT   = 80;
  localparam int HDR_ID_LSB   = 88;
  localparam int HDR_IDX_LSB  = 96;
  localparam int BEAT_BYTES   = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_HDR,
    S_DATA,
    S_DONE
  } req_state_t;
endpackage

// File: rtl/pcie_req_chunk_calc.sv
// Size of the next TLP fragment and descriptor legality, purely combinational.
module pcie_req_chunk_calc
  import pcie_adapter_pkg::*;
#(
  parameter int MAXPAYLOAD = 256,
  parameter int MAXREADREQ = 512
) (
  input  logic [23:0] addr,
  input  logic [23:0] rem,
  input  logic        rd,
  output logic [23:0] chunk,
  output logic        illegal
);
  logic [23:0] max_b;
  logic [23:0] room;

  always_comb begin
    max_b   = rd ? 24'(MAXREADREQ) : 24'(MAXPAYLOAD);
    // bytes left before the next MAX-aligned boundary (MAX is a power of 2)
    room    = max_b - (addr & (max_b - 24'd1));
    chunk   = (rem < room) ? rem : room;
    illegal = (addr[1:0] != 2'b00) || (rem[1:0] != 2'b00) ||
              (!rd && ((addr[4:0] != 5'd0) || (rem[4:0] != 5'd0)));
  end
endmodule

// File: rtl/pcie_dma_req_split.sv
// Splits one DMA descriptor into boundary-respecting memory-request TLPs and
// streams headers plus write payload beats into the PCIe user TX FIFO.
module pcie_dma_req_split
  import pcie_adapter_pkg::*;
#(
  parameter int MAXPAYLOAD = 256,
  parameter int MAXREADREQ = 512,
  parameter int DWIDTH     = 256
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [63:0]       desc_addr,
  input  logic [23:0]       desc_len,
  input  logic              desc_rd,
  input  logic [7:0]        desc_id,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              tx_ready,
  output logic [HDR_W-1:0]  tx_headin,
  output logic              tx_Hwrreq,
  output logic [DWIDTH-1:0] tx_datain,
  output logic              tx_wrreq,
  output logic              done,
  output logic [7:0]        done_id,
  output logic              done_err,
  output logic              busy
);
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  req_state_t       state, state_n;
  logic [63:0]      addr;
  logic [23:0]      rem;
  logic             rd;
  logic [7:0]       id;
  logic [7:0]       idx;
  logic [23:0]      chunk_q;
  logic [23:0]      beats;
  logic [23:0]      chunk;
  logic             illegal;
  logic             take_desc, hdr_fire, beat_take;
  logic [HDR_W-1:0] hdr_next;

  pcie_req_chunk_calc #(
    .MAXPAYLOAD(MAXPAYLOAD),
    .MAXREADREQ(MAXREADREQ)
  ) u_calc (
    .addr   (addr[23:0]),
    .rem    (rem),
    .rd     (rd),
    .chunk  (chunk),
    .illegal(illegal)
  );

  always_ff @(posedge user_clk) begin
    if (user_rst) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    take_desc = 1'b0;
    hdr_fire  = 1'b0;
    beat_take = 1'b0;
    case (state)
      S_IDLE: if (desc_valid && desc_ready) begin
        take_desc = 1'b1;
        state_n   = S_CALC;
      end
      S_CALC: state_n = (illegal || rem == 24'd0) ? S_DONE : S_HDR;
      S_HDR: if (tx_ready) begin
        hdr_fire = 1'b1;
        state_n  = rd ? S_CALC : S_DATA;
      end
      S_DATA: if (wdata_valid && wdata_ready) begin
        beat_take = 1'b1;
        if (beats == 24'd1) state_n = S_CALC;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    hdr_next = '0;
    hdr_next[HDR_ADDR_LSB +: 64] = addr;
    hdr_next[HDR_LEN_LSB  +: 16] = chunk_q[15:0];
    hdr_next[HDR_RD_BIT]         = rd;
    hdr_next[HDR_ID_LSB   +: 8]  = id;
    hdr_next[HDR_IDX_LSB  +: 8]  = idx;
  end

  // Every output is a flop; status flags are loaded from the next state.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      addr        <= '0;
      rem         <= '0;
      rd          <= 1'b0;
      id          <= '0;
      idx         <= '0;
      chunk_q     <= '0;
      beats       <= '0;
      desc_ready  <= 1'b0;
      wdata_ready <= 1'b0;
      busy        <= 1'b0;
      tx_Hwrreq   <= 1'b0;
      tx_wrreq    <= 1'b0;
      tx_headin   <= '0;
      tx_datain   <= '0;
      done        <= 1'b0;
      done_id     <= '0;
      done_err    <= 1'b0;
    end else begin
      desc_ready  <= (state_n == S_IDLE);
      wdata_ready <= (state_n == S_DATA);
      busy        <= (state_n != S_IDLE);
      done        <= (state_n == S_DONE);
      tx_Hwrreq   <= hdr_fire;
      tx_wrreq    <= beat_take;
      if (take_desc) begin
        addr <= desc_addr;
        rem  <= desc_len;
        rd   <= desc_rd;
        id   <= desc_id;
        idx  <= '0;
      end
      if (state == S_CALC) chunk_q <= chunk;
      if (state == S_CALC && state_n == S_DONE) begin
        done_id  <= id;
        done_err <= illegal;
      end
      if (hdr_fire) begin
        tx_headin <= hdr_next;
        addr      <= addr + 64'(chunk_q);
        rem       <= rem - chunk_q;
        idx       <= idx + 8'd1;
        beats     <= chunk_q >> BEAT_SHIFT;
      end
      if (beat_take) begin
        tx_datain <= wdata;
        beats     <= beats - 24'd1;
      end
    end
  end
endmodule
